// File: rtl/uart_rx_os_if.sv
// CPU-side receive bus of the oversampling UART receiver.
// The receiver drives data, status and error flags; the CPU drives pop and error-clear.
interface uart_rx_os_if;
  logic [7:0] rx_d;
  logic       rx_valid;
  logic       rx_rd;
  logic       frame_err;
  logic       overrun;
  logic       clr_err;
  logic       busy;

  modport master (
    input  rx_d, rx_valid, frame_err, overrun, busy,
    output rx_rd, clr_err
  );

  modport slave (
    output rx_d, rx_valid, frame_err, overrun, busy,
    input  rx_rd, clr_err
  );
endinterface

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver: mid-bit sampling, start-glitch rejection, stop-bit framing
// check and a small first-word-fall-through receive FIFO with sticky error flags.
module uart_rx_os #(
  parameter int OVERSAMPLE = 16,
  parameter int DEPTH      = 4
) (
  input  logic         clk_uart,
  input  logic         rst_n,
  input  logic         rx,
  uart_rx_os_if.slave  bus
);
  localparam int CW = $clog2(OVERSAMPLE);
  localparam int AW = $clog2(DEPTH);
  localparam logic [CW-1:0] HALF_M1 = CW'(OVERSAMPLE/2 - 1);
  localparam logic [CW-1:0] LAST    = CW'(OVERSAMPLE - 1);
  localparam logic [AW:0]   FULL_N  = (AW+1)'(DEPTH);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          busy_r;
  logic          frame_err_r;
  logic          overrun_r;

  logic          rx_p0;
  logic          rx_p1;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          full;
  logic          empty;
  logic          pop;
  logic          push;
  logic          stop_smp;

  // stage p0/p1: two-flop synchroniser, rx_p1 is the synchronised line
  always_ff @(posedge clk_uart) begin
    if (!rst_n) begin
      rx_p0 <= 1'b1;
      rx_p1 <= 1'b1;
    end else begin
      rx_p0 <= rx;
      rx_p1 <= rx_p0;
    end
  end

  assign full     = (count == FULL_N);
  assign empty    = (count == '0);
  assign pop      = bus.rx_rd & ~empty;
  assign stop_smp = (state == STOP) && (cnt == LAST);
  // a pop in the stop-sample cycle frees the slot the new byte needs
  assign push     = stop_smp & rx_p1 & (~full | pop);

  always_ff @(posedge clk_uart) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      bit_idx     <= '0;
      busy_r      <= 1'b0;
      frame_err_r <= 1'b0;
      overrun_r   <= 1'b0;
    end else begin
      // clear first so a same-cycle set below overrides it
      if (bus.clr_err) begin
        frame_err_r <= 1'b0;
        overrun_r   <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (!rx_p1) begin
            state  <= START;
            cnt    <= '0;
            busy_r <= 1'b1;
          end
        end
        START: begin
          if (cnt == HALF_M1) begin
            cnt     <= '0;
            bit_idx <= '0;
            if (!rx_p1) begin
              state <= DATA;
            end else begin
              state  <= IDLE;
              busy_r <= 1'b0;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DATA: begin
          if (cnt == LAST) begin
            cnt     <= '0;
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) state <= STOP;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        STOP: begin
          if (cnt == LAST) begin
            cnt <= '0;
            if (rx_p1) begin
              state  <= IDLE;
              busy_r <= 1'b0;
              if (full && !pop) overrun_r <= 1'b1;
            end else begin
              state       <= BREAK;
              frame_err_r <= 1'b1;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        BREAK: begin
          if (rx_p1) begin
            state  <= IDLE;
            busy_r <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          busy_r <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_uart) begin
    if (state == DATA && cnt == LAST) shreg <= {rx_p1, shreg[7:1]};
  end

  always_ff @(posedge clk_uart) begin
    if (push) mem[wr_ptr] <= shreg;
  end

  always_ff @(posedge clk_uart) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
  end

  assign bus.rx_d      = empty ? 8'h00 : mem[rd_ptr];
  assign bus.rx_valid  = ~empty;
  assign bus.frame_err = frame_err_r;
  assign bus.overrun   = overrun_r;
  assign bus.busy      = busy_r;
endmodule

// File: tb/tb_uart_rx_os.sv
// Directed bench for uart_rx_os: frames are driven on the falling clock edge, outputs
// are sampled on the falling edge, expected values are hand-computed constants.
module tb_uart_rx_os;
  localparam int OS = 16;

  logic clk_uart = 1'b0;
  logic rst_n;
  logic rx;
  int   checks = 0;
  int   errors = 0;

  uart_rx_os_if bus_if ();

  uart_rx_os #(.OVERSAMPLE(OS), .DEPTH(4)) dut (
    .clk_uart (clk_uart),
    .rst_n    (rst_n),
    .rx       (rx),
    .bus      (bus_if.slave)
  );

  always #5 clk_uart = ~clk_uart;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    repeat (OS) @(negedge clk_uart);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (OS) @(negedge clk_uart);
    end
    rx = stop;
    repeat (OS) @(negedge clk_uart);
    rx = 1'b1;
  endtask

  task automatic pop_chk(input string tag, input logic [7:0] exp);
    chk({tag, "_valid"}, {15'd0, bus_if.rx_valid}, 16'd1);
    chk({tag, "_data"}, {8'd0, bus_if.rx_d}, {8'd0, exp});
    bus_if.rx_rd = 1'b1;
    @(negedge clk_uart);
    bus_if.rx_rd = 1'b0;
  endtask

  task automatic pulse_clr();
    bus_if.clr_err = 1'b1;
    @(negedge clk_uart);
    bus_if.clr_err = 1'b0;
  endtask

  initial begin
    rst_n          = 1'b0;
    rx             = 1'b1;
    bus_if.rx_rd   = 1'b0;
    bus_if.clr_err = 1'b0;
    repeat (3) @(negedge clk_uart);
    chk("rst_valid", {15'd0, bus_if.rx_valid}, 16'd0);
    chk("rst_busy", {15'd0, bus_if.busy}, 16'd0);
    chk("rst_ferr", {15'd0, bus_if.frame_err}, 16'd0);
    chk("rst_ovr", {15'd0, bus_if.overrun}, 16'd0);
    chk("rst_rxd", {8'd0, bus_if.rx_d}, 16'h0000);
    rst_n = 1'b1;
    repeat (5) @(negedge clk_uart);

    // good frame 0xA5, latency 155 cycles from the start edge
    fork
      send_frame(8'hA5, 1'b1);
      begin
        repeat (154) @(negedge clk_uart);
        chk("a5_valid_154", {15'd0, bus_if.rx_valid}, 16'd0);
        @(negedge clk_uart);
        chk("a5_valid_155", {15'd0, bus_if.rx_valid}, 16'd1);
        chk("a5_data_155", {8'd0, bus_if.rx_d}, 16'h00A5);
      end
    join
    chk("a5_ferr", {15'd0, bus_if.frame_err}, 16'd0);
    pop_chk("a5_pop", 8'hA5);
    chk("a5_empty", {15'd0, bus_if.rx_valid}, 16'd0);

    // start glitch of 5 cycles
    repeat (10) @(negedge clk_uart);
    rx = 1'b0;
    repeat (5) @(negedge clk_uart);
    chk("gl_busy_hi", {15'd0, bus_if.busy}, 16'd1);
    rx = 1'b1;
    repeat (30) @(negedge clk_uart);
    chk("gl_busy_lo", {15'd0, bus_if.busy}, 16'd0);
    chk("gl_valid", {15'd0, bus_if.rx_valid}, 16'd0);
    chk("gl_ferr", {15'd0, bus_if.frame_err}, 16'd0);
    chk("gl_ovr", {15'd0, bus_if.overrun}, 16'd0);

    // framing error, held-low line, then a good 0x11
    send_frame(8'h3C, 1'b0);
    rx = 1'b0;
    chk("fe_set", {15'd0, bus_if.frame_err}, 16'd1);
    chk("fe_busy", {15'd0, bus_if.busy}, 16'd1);
    repeat (10) @(negedge clk_uart);
    pulse_clr();
    repeat (30) @(negedge clk_uart);
    chk("fe_single", {15'd0, bus_if.frame_err}, 16'd0);
    chk("fe_nopush", {15'd0, bus_if.rx_valid}, 16'd0);
    rx = 1'b1;
    repeat (20) @(negedge clk_uart);
    chk("fe_idle", {15'd0, bus_if.busy}, 16'd0);
    send_frame(8'h11, 1'b1);
    repeat (3) @(negedge clk_uart);
    pop_chk("fe_pop", 8'h11);
    chk("fe_empty", {15'd0, bus_if.rx_valid}, 16'd0);
    chk("fe_ferr0", {15'd0, bus_if.frame_err}, 16'd0);

    // five back-to-back frames into a 4-deep FIFO
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1);
    repeat (3) @(negedge clk_uart);
    chk("ov_set", {15'd0, bus_if.overrun}, 16'd1);
    for (int i = 1; i <= 4; i++) pop_chk("ov_pop", 8'(i));
    chk("ov_empty", {15'd0, bus_if.rx_valid}, 16'd0);
    pulse_clr();
    chk("ov_clr", {15'd0, bus_if.overrun}, 16'd0);

    // full FIFO, pop in the exact stop-sample cycle of the fifth frame
    for (int i = 1; i <= 4; i++) send_frame(8'(i), 1'b1);
    fork
      send_frame(8'h05, 1'b1);
      begin
        repeat (154) @(negedge clk_uart);
        bus_if.rx_rd = 1'b1;
        @(negedge clk_uart);
        bus_if.rx_rd = 1'b0;
      end
    join
    repeat (3) @(negedge clk_uart);
    chk("pp_ovr", {15'd0, bus_if.overrun}, 16'd0);
    for (int i = 2; i <= 5; i++) pop_chk("pp_pop", 8'(i));
    chk("pp_empty", {15'd0, bus_if.rx_valid}, 16'd0);

    // reset during bit 4 of a frame whose remaining bits are all 1
    repeat (5) @(negedge clk_uart);
    fork
      send_frame(8'hF0, 1'b1);
      begin
        repeat (OS * 5 + 8) @(negedge clk_uart);
        rst_n = 1'b0;
        @(negedge clk_uart);
        rst_n = 1'b1;
        chk("ab_rst_busy", {15'd0, bus_if.busy}, 16'd0);
      end
    join
    repeat (20) @(negedge clk_uart);
    chk("ab_valid", {15'd0, bus_if.rx_valid}, 16'd0);
    chk("ab_busy", {15'd0, bus_if.busy}, 16'd0);
    send_frame(8'h7E, 1'b1);
    repeat (3) @(negedge clk_uart);
    pop_chk("ab_pop", 8'h7E);
    chk("ab_empty", {15'd0, bus_if.rx_valid}, 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_rx_os.md
Name: uart_rx_os

Overview:
- Oversampling UART receiver for the CPU's serial link.
- Runs on clk_uart at OVERSAMPLE x the baud rate, so it can receive frames from the existing 1-clock-per-bit transmitter when clk_uart is divided appropriately, or from an external host.
- Provides mid-bit sampling, start-bit glitch rejection, stop-bit framing check and a small FWFT receive FIFO with overrun detection.
- Sits between the rx pin and the CPU's I/O register block.

Parameters:
- OVERSAMPLE, 16, clk_uart cycles per bit; even, >= 4.
- DEPTH, 4, FIFO entries; power of 2, >= 2.

Ports:
- clk_uart  in  1  sole clock; OVERSAMPLE x baud.
- rst_n  in  1  synchronous active-low reset.
- rx  in  1  asynchronous serial input; idle high.
- rx_d  out  8  FIFO head byte; meaningful only while rx_valid=1.
- rx_valid  out  1  FIFO non-empty.
- rx_rd  in  1  pop request; honoured only when rx_valid=1.
- frame_err  out  1  sticky: a frame had stop bit = 0.
- overrun  out  1  sticky: a good byte arrived while the FIFO was full and was dropped.
- clr_err  in  1  clears frame_err and overrun.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (rst_n=0 at a clk_uart edge):
  - state=IDLE; FIFO empty; rx_valid=0, frame_err=0, overrun=0, busy=0.
  - Synchroniser flops = 1; rx_d=0.
  - Reset mid-frame abandons the frame; no partial byte is pushed.
- Input path: rx passes through a 2-flop synchroniser to give rx_s. All decisions use rx_s, so there is 2 cycles of input latency.
- Counters: sample counter is 0..OVERSAMPLE-1; bit index is 0..7.
- IDLE: when rx_s=0, go to START with counter=0.
- START: counter increments each cycle. At counter==OVERSAMPLE/2-1 (mid start bit):
  - rx_s=0: go to DATA with counter=0 and bit=0.
  - rx_s=1: glitch; return to IDLE, nothing recorded.
- DATA:
  - At counter==OVERSAMPLE-1, shift rx_s into the shift register LSB-first, reset counter and increment bit.
  - After bit 7 is sampled, go to STOP.
- STOP: at counter==OVERSAMPLE-1, sample rx_s.
  - rx_s=1, FIFO not full: push the byte; go to IDLE in the same cycle.
  - rx_s=1, FIFO full with no pop that cycle: drop the byte, set overrun, go to IDLE.
  - rx_s=0: discard the byte, set frame_err, go to BREAK.
  - Returning to IDLE from mid stop bit allows back-to-back frames.
- BREAK: wait until rx_s=1, then go to IDLE. A held-low line yields exactly one frame_err, not repeated frames.
- FIFO (first-word fall-through):
  - rx_d = head entry. A pushed byte appears on rx_valid/rx_d the cycle after the stop-sample edge.
  - A pop (rx_rd & rx_valid) advances the head on the next edge.
  - rx_rd while empty is ignored.
  - Simultaneous push and pop while full: both take effect, count is unchanged, no overrun.
  - Simultaneous push and pop with one entry: the new byte becomes the head; rx_valid stays 1.
  - Pointers are log2(DEPTH) bits wide and wrap naturally. Full/empty are derived from an occupancy count of log2(DEPTH)+1 bits.
- Error flags:
  - Sticky until clr_err=1 or reset.
  - If clr_err and a new error occur in the same cycle, the set wins.
  - Error flags never block reception.
- Total latency: rx falling edge of start bit to rx_valid=1 = 2 + OVERSAMPLE/2 + 8*OVERSAMPLE + OVERSAMPLE + 1 cycles, nominally. For OVERSAMPLE=16 this is 155 cycles.

Test Plan:
- Frame 0xA5 at 16 cycles/bit (start, 1,0,1,0,0,1,0,1 LSB-first, stop=1) -> rx_valid rises 155 cycles after the start edge; rx_d=0xA5; frame_err=0; after one rx_rd cycle, rx_valid=0.
- rx low for 5 cycles then high -> busy pulses, returns to IDLE, rx_valid stays 0, no flags set.
- Frame 0x3C with stop bit=0, then line held low 40 cycles, then high, then a good 0x11 -> frame_err=1 (single event); FIFO holds only 0x11; clr_err clears frame_err to 0.
- 5 back-to-back good frames 0x01..0x05 with no reads (DEPTH=4) -> overrun=1; reads return 0x01,0x02,0x03,0x04, then rx_valid=0.
- FIFO full, with rx_rd asserted in the exact cycle of the 5th frame's stop sample -> overrun stays 0; reads return 0x02..0x05.
- rst_n low during bit 4 of a frame, released, then frame 0x7E -> nothing pushed from the aborted frame; rx_d=0x7E is the only entry.
